wave_capture: RTL and testbench

- Writer side of the scope sample buffer: takes ADC samples, waits for a trigger crossing, and writes a decimated, scaled record into the sample RAM.
- Write port: wr_en/wr_addr/wr_data. The waveform renderer reads the same RAM by x pixel offset.
- Each stored word is a y offset (0..H) in the renderer's coordinate system: 0 is the top row, so high voltage is drawn at the top.

---
 rtl/wave_capture.sv | 186 ++++++++++++++++++
 tb/tb_wave_capture.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_capture.sv
// Scope capture writer: arms, waits for a level crossing, then writes a decimated,
// scaled record to the sample RAM. Define WAVE_CAPTURE_AUTO_TRIGGER_EN for the auto-trigger timeout.
module wave_capture #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16,
    parameter int ADC_WIDTH  = 8,
    parameter int DEPTH      = 100,
    parameter int H          = 100,
    parameter int SHIFT      = 1,
    parameter int TIMEOUT    = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  adc_valid,
    input  logic [ADC_WIDTH-1:0]  adc_data,
    input  logic [ADC_WIDTH-1:0]  trig_level,
    input  logic                  trig_rising,
    input  logic [7:0]            decim,
    input  logic                  arm,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  armed,
    output logic                  capturing,
    output logic                  done
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    if (DEPTH < 1 || DEPTH > (1 << ADDR_WIDTH) || TIMEOUT < 1) begin : g_param_check
        $error("wave_capture: DEPTH must be 1..2**ADDR_WIDTH and TIMEOUT at least 1");
    end

    logic [1:0]            state_q, state_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [7:0]            dec_cnt_q, dec_cnt_d;
    logic [ADC_WIDTH-1:0]  prev_q, prev_d;
    logic                  prev_valid_q, prev_valid_d;

    logic                  arm_accept;
    logic                  edge_hit;
    logic                  auto_hit;
    logic                  trigger;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [ADC_WIDTH-1:0]  shifted;
    logic [31:0]           sample_ext;
    logic [31:0]           clamped;
    logic [DATA_WIDTH-1:0] scaled;

    assign arm_accept = arm && (state_q == S_IDLE || state_q == S_DONE);

    // Screen y grows downward, so the clamped sample is flipped against H.
    always_comb begin
        shifted    = adc_data >> SHIFT;
        sample_ext = 32'(shifted);
        clamped    = (sample_ext > 32'(H)) ? 32'(H) : sample_ext;
        scaled     = DATA_WIDTH'(32'(H) - clamped);
    end

    always_comb begin
        edge_hit = 1'b0;
        if (adc_valid && prev_valid_q) begin
            if (trig_rising) begin
                edge_hit = (prev_q < trig_level) && (adc_data >= trig_level);
            end else begin
                edge_hit = (prev_q > trig_level) && (adc_data <= trig_level);
            end
        end
    end

`ifdef WAVE_CAPTURE_AUTO_TRIGGER_EN
    localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] timeout_q, timeout_d;

    // Saturates at the limit so a long quiet input keeps the force pending.
    always_comb begin
        timeout_d = timeout_q;
        if (arm_accept) begin
            timeout_d = '0;
        end else if (state_q == S_ARMED && timeout_q != TO_LIMIT) begin
            timeout_d = timeout_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_q <= '0;
        end else begin
            timeout_q <= timeout_d;
        end
    end

    assign auto_hit = adc_valid && (timeout_q == TO_LIMIT);
`else
    assign auto_hit = 1'b0;
`endif

    assign trigger   = (state_q == S_ARMED) && (edge_hit || auto_hit);
    assign next_addr = wr_addr_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        dec_cnt_d    = dec_cnt_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (arm_accept) begin
                    state_d      = S_ARMED;
                    prev_valid_d = 1'b0;
                    wr_addr_d    = '0;
                end
            end
            S_ARMED: begin
                if (adc_valid) begin
                    prev_d       = adc_data;
                    prev_valid_d = 1'b1;
                end
                if (trigger) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = '0;
                    wr_data_d = scaled;
                    dec_cnt_d = decim;
                    state_d   = (LAST_ADDR == '0) ? S_DONE : S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (adc_valid) begin
                    if (dec_cnt_q == '0) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = next_addr;
                        wr_data_d = scaled;
                        dec_cnt_d = decim;
                        if (next_addr == LAST_ADDR) begin
                            state_d = S_DONE;
                        end
                    end else begin
                        dec_cnt_d = dec_cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            dec_cnt_q    <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            dec_cnt_q    <= dec_cnt_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign armed     = (state_q == S_ARMED);
    assign capturing = (state_q == S_CAPTURE);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_wave_capture.sv
// Randomized bench for wave_capture: each record is predicted from the list of valid
// samples seen after arm (trigger search, then every decim+1-th sample, scaled).
module tb_wave_capture;

    localparam int AW    = 10;
    localparam int DW    = 16;
    localparam int DEPTH = 100;
    localparam int H     = 100;
    localparam int SHIFT = 1;
    localparam int TOUT  = 50;

    logic          clk;
    logic          reset;
    logic          adc_valid;
    logic [7:0]    adc_data;
    logic [7:0]    trig_level;
    logic          trig_rising;
    logic [7:0]    decim;
    logic          arm;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          armed;
    logic          capturing;
    logic          done;

    wave_capture #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .ADC_WIDTH (8),
        .DEPTH     (DEPTH),
        .H         (H),
        .SHIFT     (SHIFT),
        .TIMEOUT   (TOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .adc_valid  (adc_valid),
        .adc_data   (adc_data),
        .trig_level (trig_level),
        .trig_rising(trig_rising),
        .decim      (decim),
        .arm        (arm),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .armed      (armed),
        .capturing  (capturing),
        .done       (done)
    );

    int unsigned n_tests;
    int unsigned n_fail;
    int unsigned cyc;
    int unsigned arm_edge;

    int unsigned s_data[$];
    int unsigned s_edge[$];
    int unsigned w_edge[$];
    int unsigned w_addr[$];
    int unsigned w_data[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            w_edge.push_back(cyc);
            w_addr.push_back(int'(wr_addr));
            w_data.push_back(int'(wr_data));
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int unsigned scale(input int unsigned x);
        int unsigned s;
        s = x >> SHIFT;
        return H - ((s > H) ? H : s);
    endfunction

    // 0 random, 1 ramp from 120 step 5, 2 falling preset then random, 3 constant 64
    function automatic logic [7:0] gen(input int mode, input int k);
        logic [7:0] v;
        v = 8'($urandom_range(0, 255));
        case (mode)
            1: v = 8'(120 + 5 * k);
            2: begin
                if (k == 0) v = 8'd95;
                else if (k == 1) v = 8'd110;
                else if (k == 2) v = 8'd105;
                else if (k == 3) v = 8'd100;
            end
            3: v = 8'd64;
            default: ;
        endcase
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        adc_valid = 1'b0;
        arm       = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic arm_dut(input logic [7:0] d, input logic [7:0] lvl, input logic rise);
        s_data.delete();
        s_edge.delete();
        w_edge.delete();
        w_addr.delete();
        w_data.delete();
        @(negedge clk);
        trig_level  = lvl;
        trig_rising = rise;
        decim       = d;
        adc_valid   = 1'b0;
        arm         = 1'b1;
        arm_edge    = cyc + 1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    task automatic run(input string name, input int mode, input logic [7:0] d,
                       input logic [7:0] lvl, input logic rise, input int vprob,
                       input int ncyc, input bit poke_arm);
        int  k;
        int  ti;
        bit  poked;
        int unsigned e_idx[$];
        arm_dut(d, lvl, rise);
        check({name, "_armed"}, 32'(armed), 32'd1);
        check({name, "_done_clr"}, 32'(done), 32'd0);
        k = 0;
        poked = 1'b0;
        for (int j = 0; j < ncyc; j++) begin
            arm = 1'b0;
            if (poke_arm && !poked && w_addr.size() > 10 && w_addr.size() < DEPTH - 5) begin
                arm   = 1'b1;
                poked = 1'b1;
            end
            if (int'($urandom_range(0, 99)) < vprob) begin
                adc_valid = 1'b1;
                adc_data  = gen(mode, k);
                s_data.push_back(int'(adc_data));
                s_edge.push_back(cyc + 1);
                k++;
            end else begin
                adc_valid = 1'b0;
                adc_data  = 8'($urandom_range(0, 255));
            end
            @(negedge clk);
        end
        arm       = 1'b0;
        adc_valid = 1'b0;
        repeat (4) @(negedge clk);

        ti = -1;
        for (int i = 0; i < s_data.size(); i++) begin
            bit hit;
            hit = 1'b0;
            if (i > 0) begin
                if (rise) hit = (s_data[i-1] < lvl) && (s_data[i] >= lvl);
                else      hit = (s_data[i-1] > lvl) && (s_data[i] <= lvl);
            end
`ifdef WAVE_CAPTURE_AUTO_TRIGGER_EN
            if (s_edge[i] >= arm_edge + TOUT) hit = 1'b1;
`endif
            if (hit) begin
                ti = i;
                break;
            end
        end
        if (ti >= 0) begin
            for (int idx = ti; idx < s_data.size() && e_idx.size() < DEPTH; idx += int'(d) + 1)
                e_idx.push_back(idx);
        end

        check({name, "_count"}, w_addr.size(), e_idx.size());
        for (int i = 0; i < e_idx.size() && i < w_addr.size(); i++) begin
            check($sformatf("%s_addr[%0d]", name, i), w_addr[i], i);
            check($sformatf("%s_data[%0d]", name, i), w_data[i], scale(s_data[e_idx[i]]));
            check($sformatf("%s_edge[%0d]", name, i), w_edge[i], s_edge[e_idx[i]]);
        end
        if (e_idx.size() == DEPTH) begin
            check({name, "_done"}, 32'(done), 32'd1);
            check({name, "_capturing"}, 32'(capturing), 32'd0);
            check({name, "_armed_end"}, 32'(armed), 32'd0);
        end else if (ti >= 0) begin
            check({name, "_capturing"}, 32'(capturing), 32'd1);
            check({name, "_done"}, 32'(done), 32'd0);
        end else begin
            check({name, "_armed_end"}, 32'(armed), 32'd1);
            check({name, "_done"}, 32'(done), 32'd0);
        end
        if (e_idx.size() != DEPTH) do_reset();
    endtask

    task automatic reset_mid_capture();
        bit hit;
        int k;
        arm_dut(8'd0, 8'd128, 1'b1);
        hit = 1'b0;
        k = 0;
        for (int j = 0; j < 300; j++) begin
            if (wr_en === 1'b1 && wr_addr == AW'(37)) begin
                hit = 1'b1;
                break;
            end
            adc_valid = 1'b1;
            adc_data  = gen(1, k);
            k++;
            @(negedge clk);
        end
        check("mid_reach_addr37", 32'(hit), 32'd1);
        reset     = 1'b1;
        adc_valid = 1'b0;
        #1;
        check("mid_wr_en", 32'(wr_en), 32'd0);
        check("mid_capturing", 32'(capturing), 32'd0);
        check("mid_armed", 32'(armed), 32'd0);
        check("mid_done", 32'(done), 32'd0);
        check("mid_wr_addr", 32'(wr_addr), 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        reset       = 1'b1;
        adc_valid   = 1'b0;
        adc_data    = '0;
        trig_level  = '0;
        trig_rising = 1'b1;
        decim       = '0;
        arm         = 1'b0;
        #1;
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_armed", 32'(armed), 32'd0);
        check("rst_capturing", 32'(capturing), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        run("ramp", 1, 8'd0, 8'd128, 1'b1, 100, 130, 1'b0);
        check("ramp_first", (w_data.size() > 0) ? w_data[0] : 32'hFFFF, 32'd35);
        check("ramp_second", (w_data.size() > 1) ? w_data[1] : 32'hFFFF, 32'd33);

        run("fall", 2, 8'd0, 8'd100, 1'b0, 100, 130, 1'b0);
        check("fall_first", (w_data.size() > 0) ? w_data[0] : 32'hFFFF, 32'd50);
        check("fall_first_edge", (w_edge.size() > 0) ? w_edge[0] : 32'hFFFF,
              (s_edge.size() > 3) ? s_edge[3] : 32'hFFFE);

        run("decim2", 0, 8'd2, 8'd128, 1'b1, 100, 400, 1'b0);

        for (int r = 0; r < 4; r++) begin
            logic [7:0] d;
            int vp;
            d  = 8'($urandom_range(0, 3));
            vp = int'($urandom_range(50, 100));
            run($sformatf("rand%0d", r), 0, d, 8'($urandom_range(40, 215)),
                1'($urandom_range(0, 1)), vp, (120 * (int'(d) + 1) * 100) / vp + 60, 1'b1);
        end

        reset_mid_capture();
        run("after_rst", 0, 8'd1, 8'd128, 1'b1, 80, 400, 1'b1);

        run("flat64", 3, 8'd0, 8'd128, 1'b1, 100, 1000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
